// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared datapath types for the 5-stage MIPS pipeline.
//   word_t        : 32-bit data/address word
//   regbits_t     : 5-bit register-file index
//   exmem_state_t : data-memory request state held by the EX/MEM register
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // IDLE : no data-memory request outstanding
    // REQ  : request live toward the cache, waiting for dhit
    // DONE : request finished, captured load data held for MEM/WB
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } exmem_state_t;

endpackage

// File: rtl/exmem_if.sv
// ---------------------------------------------------------------------------
// exmem_if
// Signal bundle around the EX/MEM pipeline register.
//   Inputs to the register : en, flush, execute-stage payload and control,
//                            cache response (dhit, dmemload)
//   Outputs of the register: registered payload/control, sticky halt,
//                            cache request (dmemREN/WEN, addr, store data),
//                            load data for MEM/WB, mem_stall
// Modports:
//   exmem : the pipeline register itself
//   tb    : whatever drives the register (pipeline glue or a testbench)
// ---------------------------------------------------------------------------
interface exmem_if;
    import cpu_types_pkg::*;

    // pipeline control
    logic     en;
    logic     flush;

    // execute-stage payload
    word_t    aluout_in;
    word_t    rdat2_in;
    regbits_t wsel_in;
    word_t    pcplus4_in;

    // control bits from ID/EX
    logic     MemToReg_in;
    logic     regWEN_in;
    logic     dMemREN_in;
    logic     dMemWEN_in;
    logic     JType_in;
    logic     Halt_in;

    // cache response
    logic     dhit;
    word_t    dmemload;

    // registered payload toward MEM/WB
    word_t    aluout_out;
    word_t    rdat2_out;
    word_t    pcplus4_out;
    regbits_t wsel_out;
    logic     MemToReg_out;
    logic     regWEN_out;
    logic     JType_out;
    logic     Halt_out;

    // cache request and load data
    logic     dmemREN;
    logic     dmemWEN;
    word_t    dmemaddr;
    word_t    dmemstore;
    word_t    dload_out;
    logic     mem_stall;

    modport exmem (
        input  en, flush,
        input  aluout_in, rdat2_in, wsel_in, pcplus4_in,
        input  MemToReg_in, regWEN_in, dMemREN_in, dMemWEN_in, JType_in, Halt_in,
        input  dhit, dmemload,
        output aluout_out, rdat2_out, pcplus4_out, wsel_out,
        output MemToReg_out, regWEN_out, JType_out, Halt_out,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dload_out, mem_stall
    );

    modport tb (
        output en, flush,
        output aluout_in, rdat2_in, wsel_in, pcplus4_in,
        output MemToReg_in, regWEN_in, dMemREN_in, dMemWEN_in, JType_in, Halt_in,
        output dhit, dmemload,
        input  aluout_out, rdat2_out, pcplus4_out, wsel_out,
        input  MemToReg_out, regWEN_out, JType_out, Halt_out,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dload_out, mem_stall
    );

endinterface

// File: rtl/exmem_reg.sv
// ---------------------------------------------------------------------------
// exmem_reg
// EX/MEM pipeline register. Latches execute-stage results and control,
// issues the data-memory request to the cache and holds the pipeline
// (mem_stall) until dhit, then hands the load data to MEM/WB.
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous, active-high reset
//   bus : exmem_if.exmem bundle (payload in/out, cache request/response)
// ---------------------------------------------------------------------------
module exmem_reg
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    exmem_if.exmem bus
);

    exmem_state_t state;
    logic         ren_q;     // latched read request of the instruction in MEM
    logic         wen_q;     // latched write request of the instruction in MEM
    word_t        dload_q;   // last load data returned by the cache

    logic         stall;
    logic         ld;
    logic         ren_eff;
    logic         wen_eff;
    logic         in_req;

    assign in_req = (state == REQ);

    // A pending request without dhit freezes this stage; a dhit lets the
    // next instruction load in that same cycle.
    assign stall = in_req & ~bus.dhit;
    assign ld    = bus.en & ~stall;

    // Store wins when both requests are set; a flush kills both.
    assign wen_eff = bus.dMemWEN_in & ~bus.flush;
    assign ren_eff = bus.dMemREN_in & ~bus.dMemWEN_in & ~bus.flush;

    always_ff @(posedge CLK) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state            <= IDLE;
            ren_q            <= 1'b0;
            wen_q            <= 1'b0;
            dload_q          <= '0;
            bus.aluout_out   <= '0;
            bus.rdat2_out    <= '0;
            bus.pcplus4_out  <= '0;
            bus.wsel_out     <= '0;
            bus.MemToReg_out <= 1'b0;
            bus.regWEN_out   <= 1'b0;
            bus.JType_out    <= 1'b0;
            bus.Halt_out     <= 1'b0;
        end else begin
            if (in_req && bus.dhit) begin
                dload_q <= bus.dmemload;
            end

            if (ld) begin
                bus.aluout_out   <= bus.aluout_in;
                bus.rdat2_out    <= bus.rdat2_in;
                bus.pcplus4_out  <= bus.pcplus4_in;
                bus.wsel_out     <= bus.wsel_in;
                bus.MemToReg_out <= bus.MemToReg_in & ~bus.flush;
                bus.regWEN_out   <= bus.regWEN_in & ~bus.flush;
                bus.JType_out    <= bus.JType_in & ~bus.flush;
                ren_q            <= ren_eff;
                wen_q            <= wen_eff;
                // Follows the incoming instruction, even when the current
                // request completes in this same cycle.
                state            <= (ren_eff | wen_eff) ? REQ : IDLE;
                // Halt is sticky: only reset clears it.
                if (bus.Halt_in && !bus.flush) begin
                    bus.Halt_out <= 1'b1;
                end
            end else if (in_req && bus.dhit) begin
                state <= DONE;
            end
        end
    end

    assign bus.dmemREN   = in_req & ren_q;
    assign bus.dmemWEN   = in_req & wen_q;
    assign bus.mem_stall = stall;
    assign bus.dmemaddr  = bus.aluout_out;
    assign bus.dmemstore = bus.rdat2_out;
    // While the request is live MEM/WB sees the cache data directly, so a
    // same-cycle advance still picks up the load result.
    assign bus.dload_out = in_req ? bus.dmemload : dload_q;

endmodule

// File: tb/tb_exmem_reg.sv
// ---------------------------------------------------------------------------
// tb_exmem_reg
// Self-checking bench for exmem_reg: directed scenarios followed by random
// traffic compared against a transaction-level reference model (a pending
// request flag plus the last instruction's fields).
// ---------------------------------------------------------------------------
module tb_exmem_reg;
    import cpu_types_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exmem_if bus();

    exmem_reg dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: what MEM should currently see
    // ------------------------------------------------------------------
    logic     m_pend;       // a memory request is outstanding
    logic     m_ren, m_wen;
    word_t    m_alu, m_rdat2, m_pc4, m_dload;
    regbits_t m_wsel;
    logic     m_m2r, m_rw, m_j, m_halt;

    task automatic model_clear();
        m_pend = 0; m_ren = 0; m_wen = 0;
        m_alu = 0; m_rdat2 = 0; m_pc4 = 0; m_dload = 0; m_wsel = 0;
        m_m2r = 0; m_rw = 0; m_j = 0; m_halt = 0;
    endtask

    // One clock edge; the model advances from the inputs present at the edge.
    task automatic tick();
        logic adv;
        @(posedge clk);
        adv = bus.en && !(m_pend && !bus.dhit);
        if (rst) begin
            model_clear();
        end else begin
            if (m_pend && bus.dhit) begin
                m_dload = bus.dmemload;
                m_pend  = 0;
            end
            if (adv) begin
                m_alu   = bus.aluout_in;
                m_rdat2 = bus.rdat2_in;
                m_pc4   = bus.pcplus4_in;
                m_wsel  = bus.wsel_in;
                m_m2r   = bus.MemToReg_in && !bus.flush;
                m_rw    = bus.regWEN_in && !bus.flush;
                m_j     = bus.JType_in && !bus.flush;
                m_wen   = bus.dMemWEN_in && !bus.flush;
                m_ren   = bus.dMemREN_in && !bus.dMemWEN_in && !bus.flush;
                m_pend  = m_ren || m_wen;
                if (bus.Halt_in && !bus.flush) m_halt = 1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.en = 0; bus.flush = 0;
        bus.aluout_in = 0; bus.rdat2_in = 0; bus.wsel_in = 0; bus.pcplus4_in = 0;
        bus.MemToReg_in = 0; bus.regWEN_in = 0; bus.dMemREN_in = 0;
        bus.dMemWEN_in = 0; bus.JType_in = 0; bus.Halt_in = 0;
        bus.dhit = 0; bus.dmemload = 0;
    endtask

    task automatic set_instr(input word_t alu, input word_t rd2, input logic ren,
                             input logic wen, input logic rw, input logic halt);
        bus.aluout_in  = alu;
        bus.rdat2_in   = rd2;
        bus.dMemREN_in = ren;
        bus.dMemWEN_in = wen;
        bus.regWEN_in  = rw;
        bus.MemToReg_in = ren;
        bus.Halt_in    = halt;
        bus.wsel_in    = 5'd3;
        bus.pcplus4_in = alu + 32'd4;
        bus.JType_in   = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        checks++;
        if (bus.aluout_out !== 32'h0 || bus.Halt_out !== 1'b0 || bus.regWEN_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got alu=%h halt=%b rw=%b want 0", bus.aluout_out, bus.Halt_out, bus.regWEN_out);
        end
        checks++;
        if (bus.dmemREN !== 1'b0 || bus.dmemWEN !== 1'b0 || bus.mem_stall !== 1'b0 || bus.dload_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_request got ren=%b wen=%b stall=%b dload=%h want 0", bus.dmemREN, bus.dmemWEN, bus.mem_stall, bus.dload_out);
        end

        // reset in the middle of a request, with a dhit that must be ignored
        set_instr(32'h1234, 32'h0, 1, 0, 1, 0);
        bus.en = 1;
        tick();
        bus.en = 0;
        #1;
        checks++;
        if (bus.dmemREN !== 1'b1 || bus.mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_req got ren=%b stall=%b want 1 1", bus.dmemREN, bus.mem_stall);
        end
        rst = 1; bus.dhit = 1; bus.dmemload = 32'h5555;
        tick();
        rst = 0; bus.dhit = 0;
        #1;
        checks++;
        if (bus.aluout_out !== 32'h0 || bus.dmemREN !== 1'b0 || bus.mem_stall !== 1'b0 || bus.dload_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_req got alu=%h ren=%b stall=%b dload=%h want 0 0 0 0", bus.aluout_out, bus.dmemREN, bus.mem_stall, bus.dload_out);
        end
        bus.dmemload = 0;
    endtask

    task automatic test_load();
        clear_inputs();
        set_instr(32'h40, 32'h0, 1, 0, 1, 0);
        bus.en = 1;
        tick();
        bus.aluout_in = 32'h999;
        #1;
        checks++;
        if (bus.dmemREN !== 1'b1 || bus.dmemaddr !== 32'h40 || bus.mem_stall !== 1'b1 || bus.MemToReg_out !== 1'b1) begin
            failures++;
            $display("FAIL load_issue got ren=%b addr=%h stall=%b m2r=%b want 1 00000040 1 1", bus.dmemREN, bus.dmemaddr, bus.mem_stall, bus.MemToReg_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.dmemaddr !== 32'h40 || bus.mem_stall !== 1'b1 || bus.dmemREN !== 1'b1) begin
                failures++;
                $display("FAIL load_hold%0d got addr=%h stall=%b ren=%b want 00000040 1 1", i, bus.dmemaddr, bus.mem_stall, bus.dmemREN);
            end
        end
        bus.en = 0; bus.dhit = 1; bus.dmemload = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.mem_stall !== 1'b0 || bus.dload_out !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_dhit got stall=%b dload=%h want 0 deadbeef", bus.mem_stall, bus.dload_out);
        end
        tick();
        bus.dhit = 0; bus.dmemload = 0;
        #1;
        checks++;
        if (bus.dmemREN !== 1'b0 || bus.mem_stall !== 1'b0 || bus.dload_out !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_done got ren=%b stall=%b dload=%h want 0 0 deadbeef", bus.dmemREN, bus.mem_stall, bus.dload_out);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        set_instr(32'h80, 32'hCAFEF00D, 0, 1, 0, 0);
        bus.en = 1;
        tick();
        set_instr(32'h100, 32'h0, 1, 0, 1, 0);
        bus.dhit = 1;
        #1;
        checks++;
        if (bus.dmemWEN !== 1'b1 || bus.dmemREN !== 1'b0 || bus.dmemstore !== 32'hCAFEF00D || bus.mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL store_issue got wen=%b ren=%b store=%h stall=%b want 1 0 cafef00d 0", bus.dmemWEN, bus.dmemREN, bus.dmemstore, bus.mem_stall);
        end
        tick();
        bus.dhit = 0; bus.en = 0;
        #1;
        checks++;
        if (bus.dmemREN !== 1'b1 || bus.dmemWEN !== 1'b0 || bus.dmemaddr !== 32'h100 || bus.mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_next got ren=%b wen=%b addr=%h stall=%b want 1 0 00000100 1", bus.dmemREN, bus.dmemWEN, bus.dmemaddr, bus.mem_stall);
        end
        bus.dhit = 1; bus.dmemload = 32'h11;
        tick();
        bus.dhit = 0; bus.dmemload = 0;
    endtask

    task automatic test_flush();
        clear_inputs();
        set_instr(32'h200, 32'h7, 0, 1, 1, 0);
        bus.en = 1; bus.flush = 1;
        tick();
        bus.en = 0; bus.flush = 0;
        #1;
        checks++;
        if (bus.dmemWEN !== 1'b0 || bus.regWEN_out !== 1'b0 || bus.mem_stall !== 1'b0 || bus.aluout_out !== 32'h200) begin
            failures++;
            $display("FAIL flush_bubble got wen=%b rw=%b stall=%b alu=%h want 0 0 0 00000200", bus.dmemWEN, bus.regWEN_out, bus.mem_stall, bus.aluout_out);
        end
    endtask

    task automatic test_both_req();
        clear_inputs();
        set_instr(32'h44, 32'h5, 1, 1, 0, 0);
        bus.en = 1;
        tick();
        bus.en = 0;
        #1;
        checks++;
        if (bus.dmemWEN !== 1'b1 || bus.dmemREN !== 1'b0) begin
            failures++;
            $display("FAIL both_req got wen=%b ren=%b want 1 0", bus.dmemWEN, bus.dmemREN);
        end
        bus.dhit = 1;
        tick();
        bus.dhit = 0;
    endtask

    task automatic test_halt();
        clear_inputs();
        set_instr(32'h8, 32'h0, 0, 0, 0, 1);
        bus.en = 1;
        tick();
        bus.en = 0;
        #1;
        checks++;
        if (bus.Halt_out !== 1'b1) begin
            failures++;
            $display("FAIL halt_set got %b want 1", bus.Halt_out);
        end
        bus.Halt_in = 0; bus.en = 1;
        tick(); tick();
        bus.en = 0;
        checks++;
        if (bus.Halt_out !== 1'b1) begin
            failures++;
            $display("FAIL halt_sticky got %b want 1", bus.Halt_out);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (bus.Halt_out !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset got %b want 0", bus.Halt_out);
        end
        bus.Halt_in = 1; bus.en = 1; bus.flush = 1;
        tick();
        bus.Halt_in = 0; bus.en = 0; bus.flush = 0;
        checks++;
        if (bus.Halt_out !== 1'b0) begin
            failures++;
            $display("FAIL halt_flushed got %b want 0", bus.Halt_out);
        end
    endtask

    task automatic test_random();
        logic [168:0] got_reg, exp_reg;
        logic [34:0]  got_live, exp_live;
        for (int n = 0; n < 400; n++) begin
            rst             = ($urandom_range(0, 49) == 0);
            bus.en          = ($urandom_range(0, 9) < 7);
            bus.flush       = ($urandom_range(0, 7) == 0);
            bus.aluout_in   = $urandom;
            bus.rdat2_in    = $urandom;
            bus.pcplus4_in  = $urandom;
            bus.wsel_in     = regbits_t'($urandom);
            bus.MemToReg_in = 1'($urandom);
            bus.regWEN_in   = 1'($urandom);
            bus.dMemREN_in  = 1'($urandom);
            bus.dMemWEN_in  = 1'($urandom);
            bus.JType_in    = 1'($urandom);
            bus.Halt_in     = ($urandom_range(0, 19) == 0);
            bus.dhit        = ($urandom_range(0, 2) == 0);
            bus.dmemload    = $urandom;
            #1;
            got_reg = {bus.aluout_out, bus.rdat2_out, bus.pcplus4_out, bus.wsel_out,
                       bus.MemToReg_out, bus.regWEN_out, bus.JType_out, bus.Halt_out,
                       bus.dmemaddr, bus.dmemstore};
            exp_reg = {m_alu, m_rdat2, m_pc4, m_wsel, m_m2r, m_rw, m_j, m_halt, m_alu, m_rdat2};
            checks++;
            if (got_reg !== exp_reg) begin
                failures++;
                $display("FAIL rand_regs cycle %0d got %h want %h", n, got_reg, exp_reg);
            end
            got_live = {bus.dmemREN, bus.dmemWEN, bus.mem_stall, bus.dload_out};
            exp_live = {m_pend && m_ren, m_pend && m_wen, m_pend && !bus.dhit,
                        m_pend ? bus.dmemload : m_dload};
            checks++;
            if (got_live !== exp_live) begin
                failures++;
                $display("FAIL rand_live cycle %0d got %h want %h", n, got_live, exp_live);
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1;
        model_clear();
        clear_inputs();
        test_reset();
        test_load();
        test_back_to_back();
        test_flush();
        test_both_req();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
